// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Provides backpressure, synchronous flush, r0 write suppression, forwarding tap and a bubble counter.
module mem_wb_skid_stage #(
    parameter int DATA_W           = 16,
    parameter int RD_W             = 3,
    parameter int ZERO_REG_DISCARD = 1,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_reg_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write,
    output logic              fwd_valid,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_main_data;
    logic [RD_W-1:0]    r_main_rd;
    logic               r_main_we;
    logic [DATA_W-1:0]  r_skid_data;
    logic [RD_W-1:0]    r_skid_rd;
    logic               r_skid_we;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_in_we;

    // Skid is occupied exactly in FULL, so readiness depends only on registered state.
    assign in_ready      = (r_state != S_FULL) & ~rst;
    assign out_valid     = (r_state != S_EMPTY);
    assign out_data      = r_main_data;
    assign out_rd        = r_main_rd;
    assign out_reg_write = r_main_we & out_valid;
    assign fwd_valid     = out_reg_write;
    assign occupancy     = r_state;
    assign bubble_cnt    = r_bubble_cnt;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_in_we    = in_reg_write & ~((ZERO_REG_DISCARD != 0) && (in_rd == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main_data <= '0;
            r_main_rd   <= '0;
            r_main_we   <= 1'b0;
            r_skid_data <= '0;
            r_skid_rd   <= '0;
            r_skid_we   <= 1'b0;
        end else if (flush) begin
            // Held data/rd stay visible; only the beat validity is killed.
            r_state     <= S_EMPTY;
            r_main_we   <= 1'b0;
            r_skid_data <= '0;
            r_skid_rd   <= '0;
            r_skid_we   <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= S_ONE;
                        r_main_data <= in_data;
                        r_main_rd   <= in_rd;
                        r_main_we   <= w_in_we;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_data <= in_data;
                        r_main_rd   <= in_rd;
                        r_main_we   <= w_in_we;
                    end else if (w_out_fire) begin
                        r_state   <= S_EMPTY;
                        r_main_we <= 1'b0;
                    end else if (w_in_fire) begin
                        r_state     <= S_FULL;
                        r_skid_data <= in_data;
                        r_skid_rd   <= in_rd;
                        r_skid_we   <= w_in_we;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        r_state     <= S_ONE;
                        r_main_data <= r_skid_data;
                        r_main_rd   <= r_skid_rd;
                        r_main_we   <= r_skid_we;
                        r_skid_we   <= 1'b0;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (out_ready && !out_valid && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based reference model.
module tb_mem_wb_skid_stage;

    localparam int DATA_W  = 16;
    localparam int RD_W    = 3;
    localparam int CNT_W   = 4;
    localparam int BUB_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;
    logic              in_reg_write;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_reg_write;
    logic              fwd_valid;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;

    mem_wb_skid_stage #(
        .DATA_W(DATA_W), .RD_W(RD_W), .ZERO_REG_DISCARD(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .fwd_valid(fwd_valid),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: FIFO of at most two beats, plus last-shown data/rd and bubble count.
    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [RD_W-1:0]   rd;
        logic              we;
    } beat_t;

    beat_t q[$];
    beat_t nb;
    logic [DATA_W-1:0] m_data;
    logic [RD_W-1:0]   m_rd;
    int    m_bub;
    bit    m_live = 0;
    int    m_sz;
    bit    m_ofire, m_ifire;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_data = '0;
            m_rd   = '0;
            m_bub  = 0;
            m_live = 1;
        end else if (m_live) begin
            m_sz    = q.size();
            m_ofire = out_ready && (m_sz > 0);
            m_ifire = in_valid && (m_sz < 2);
            if (out_ready && m_sz == 0 && m_bub < BUB_MAX) m_bub++;
            if (flush) begin
                q.delete();
            end else begin
                if (m_ofire) void'(q.pop_front());
                if (m_ifire) begin
                    nb.d  = in_data;
                    nb.rd = in_rd;
                    nb.we = in_reg_write && (in_rd != 0);
                    q.push_back(nb);
                end
            end
            if (q.size() > 0) begin
                m_data = q[0].d;
                m_rd   = q[0].rd;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("m_out_data", 32'(out_data), 32'(m_data));
            chk("m_out_rd", 32'(out_rd), 32'(m_rd));
            chk("m_out_reg_write", 32'(out_reg_write), 32'((q.size() > 0) ? q[0].we : 1'b0));
            chk("m_fwd_valid", 32'(fwd_valid), 32'((q.size() > 0) ? q[0].we : 1'b0));
            chk("m_occupancy", 32'(occupancy), 32'(q.size()));
            chk("m_in_ready", 32'(in_ready), 32'(!rst && q.size() < 2));
            chk("m_bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] rd, input logic we);
        in_valid     = v;
        in_data      = d;
        in_rd        = rd;
        in_reg_write = we;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 16'h9999, 3'd1, 1'b1);

        // Reset held two cycles with a beat offered
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_bubble", 32'(bubble_cnt), 32'd0);
        rst = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("post_rst_no_beat", 32'(out_valid), 32'd0);

        // Streaming at full throughput
        out_ready = 1'b1;
        drive(1'b1, 16'h1111, 3'd1, 1'b1); tick();
        chk("s1_data", 32'(out_data), 32'h1111);
        chk("s1_occ", 32'(occupancy), 32'd1);
        chk("s1_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 16'h2222, 3'd2, 1'b1); tick();
        chk("s2_data", 32'(out_data), 32'h2222);
        chk("s2_occ", 32'(occupancy), 32'd1);
        drive(1'b1, 16'h3333, 3'd3, 1'b0); tick();
        chk("s3_data", 32'(out_data), 32'h3333);
        chk("s3_we", 32'(out_reg_write), 32'd0);
        chk("s3_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 16'h0, 3'd0, 1'b0); tick();
        chk("s_drain", 32'(out_valid), 32'd0);

        // Backpressure fills the skid
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 3'd4, 1'b1); tick();
        drive(1'b1, 16'hBBBB, 3'd5, 1'b1); tick();
        chk("bp_occ", 32'(occupancy), 32'd2);
        chk("bp_ready", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'(out_data), 32'hAAAA);
        drive(1'b0, 16'h0, 3'd0, 1'b0); tick();
        chk("bp_still_hold", 32'(out_data), 32'hAAAA);
        out_ready = 1'b1; tick();
        chk("bp_b_next", 32'(out_data), 32'hBBBB);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("bp_empty", 32'(occupancy), 32'd0);

        // Flush while full, with a beat offered in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 3'd4, 1'b1); tick();
        drive(1'b1, 16'hBBBB, 3'd5, 1'b1); tick();
        flush = 1'b1;
        drive(1'b1, 16'hCCCC, 3'd6, 1'b1); tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_we", 32'(out_reg_write), 32'd0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        chk("fl_data_held", 32'(out_data), 32'hAAAA);
        out_ready = 1'b1; tick(); tick();
        chk("fl_nothing", 32'(out_valid), 32'd0);

        // Write to r0 is suppressed
        out_ready = 1'b0;
        drive(1'b1, 16'h5555, 3'd0, 1'b1); tick();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        chk("r0_data", 32'(out_data), 32'h5555);
        chk("r0_valid", 32'(out_valid), 32'd1);
        chk("r0_we", 32'(out_reg_write), 32'd0);
        chk("r0_fwd", 32'(fwd_valid), 32'd0);
        out_ready = 1'b1; tick();

        // Bubble counter saturation after a mid-run reset
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("bub_cleared", 32'(bubble_cnt), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("bub_5", 32'(bubble_cnt), 32'd5);
        for (int i = 0; i < 15; i++) tick();
        chk("bub_sat", 32'(bubble_cnt), 32'd15);
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("bub_flush_keep", 32'(bubble_cnt), 32'd15);

        // Randomized traffic against the model
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
